// File: rtl/mips_wb_pkg.sv
// Shared definitions for the register write-back path.
//   - dst_sel encodings for selecting the destination register
//   - architectural register constants ($zero, $ra)
//   - write-back FSM state encoding
//   - metadata carried by each queued result entry
//   - resolve_dst(): maps dst_sel / rt / rd to a 5-bit register index
package mips_wb_pkg;

  typedef enum logic [1:0] {
    DstRt   = 2'b00,
    DstRd   = 2'b01,
    DstLink = 2'b10,
    DstRsvd = 2'b11
  } dst_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitMem
  } wb_state_e;

  // Per-entry metadata; the data word is stored alongside it in the queue.
  typedef struct packed {
    logic       wr;
    logic       is_load;
    logic [4:0] dst;
  } wb_meta_t;

  // The reserved encoding resolves to $zero so it can never produce a write.
  function automatic logic [4:0] resolve_dst(input logic [1:0] sel,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd);
    logic [4:0] dst;
    unique case (sel)
      DstRt:   dst = rt;
      DstRd:   dst = rd;
      DstLink: dst = REG_RA;
      default: dst = REG_ZERO;
    endcase
    return dst;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order result queue for the write-back unit.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (flushes pointers/count)
//   push, push_meta,
//   push_data           enqueue one entry (caller guarantees !full)
//   pop                 dequeue the head (caller guarantees !empty)
//   full, empty, count  occupancy
//   head_meta/head_data peek at the oldest entry
//   next_is_load        is_load of the entry behind the head (valid when count > 1)
//   pend_valid/pend_reg oldest entry with wr=1, 0/0 if none
module wb_fifo
  import mips_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  wb_meta_t                      push_meta,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output wb_meta_t                      head_meta,
  output logic [DATA_W-1:0]             head_data,
  output logic                          next_is_load,
  output logic                          pend_valid,
  output logic [4:0]                    pend_reg
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  wb_meta_t          meta_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q;

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        meta_q[wr_ptr_q] <= push_meta;
        data_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

  assign count        = count_q;
  assign full         = (count_q == CntW'(DEPTH));
  assign empty        = (count_q == '0);
  assign head_meta    = meta_q[rd_ptr_q];
  assign head_data    = data_q[rd_ptr_q];
  assign next_is_load = meta_q[rd_ptr_q + PtrW'(1)].is_load;

  // Walk youngest to oldest so the oldest writing entry wins.
  always_comb begin
    pend_valid = 1'b0;
    pend_reg   = REG_ZERO;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if ((CntW'(i) < count_q) && meta_q[rd_ptr_q + PtrW'(i)].wr) begin
        pend_valid = 1'b1;
        pend_reg   = meta_q[rd_ptr_q + PtrW'(i)].dst;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write driver for the non-pipelined MIPS core.
// Takes completed-instruction results from execute, queues them in order, waits for
// load data where needed and issues one register-file write per committed instruction.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready             execute result handshake
//   in_wr_en, in_is_load,
//   in_dst_sel, in_rt, in_rd,
//   in_alu_data, in_link_data     result description and data
//   mem_valid, mem_data           load data return (single-cycle pulse)
//   write_reg/write_data/reg_write register-file write port (registered)
//   pend_valid/pend_reg           oldest uncommitted writing destination
//   retired_cnt                   count of issued writes (wraps)
module reg_writeback_unit
  import mips_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wr_en,
  input  logic              in_is_load,
  input  logic [1:0]        in_dst_sel,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [DATA_W-1:0] in_link_data,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic              pend_valid,
  output logic [4:0]        pend_reg,
  output logic [15:0]       retired_cnt
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  // Incoming entry
  wb_meta_t          in_meta;
  logic [DATA_W-1:0] in_data;
  logic              accept;

  always_comb begin
    in_meta.dst     = resolve_dst(in_dst_sel, in_rt, in_rd);
    in_meta.is_load = in_is_load;
    in_meta.wr      = in_wr_en && (in_meta.dst != REG_ZERO) && (in_dst_sel != DstRsvd);
    in_data         = (in_dst_sel == DstLink) ? in_link_data : in_alu_data;
  end

  // Queue
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  wb_meta_t          head_meta;
  logic [DATA_W-1:0] head_data;
  logic              next_is_load;

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;

  wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (fifo_push),
    .push_meta    (in_meta),
    .push_data    (in_data),
    .pop          (fifo_pop),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count),
    .head_meta    (head_meta),
    .head_data    (head_data),
    .next_is_load (next_is_load),
    .pend_valid   (pend_valid),
    .pend_reg     (pend_reg)
  );

  // Issue decision
  wb_state_e         state_q, state_d;
  logic              issue, bypass;
  logic              iss_wr;
  logic [4:0]        iss_dst;
  logic [DATA_W-1:0] iss_data;

  // StIdle implies the queue is empty. A non-load arriving then is issued on the
  // same edge it is accepted, so it never occupies a slot; loads always queue so
  // that mem_valid is only honoured once the load is already the head.
  always_comb begin
    issue    = 1'b0;
    bypass   = 1'b0;
    fifo_pop = 1'b0;
    iss_wr   = head_meta.wr;
    iss_dst  = head_meta.dst;
    iss_data = head_data;
    unique case (state_q)
      StIdle: begin
        if (accept && !in_is_load) begin
          bypass   = 1'b1;
          issue    = 1'b1;
          iss_wr   = in_meta.wr;
          iss_dst  = in_meta.dst;
          iss_data = in_data;
        end
      end
      StIssue: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          issue    = 1'b1;
        end
      end
      StWaitMem: begin
        if (mem_valid && !fifo_empty) begin
          fifo_pop = 1'b1;
          issue    = 1'b1;
          iss_data = mem_data;
        end
      end
      default: ;
    endcase
  end

  assign fifo_push = accept && !bypass;

  // Next state follows whichever entry will be at the head after this edge.
  logic nxt_valid, nxt_is_load;

  always_comb begin
    nxt_valid   = 1'b0;
    nxt_is_load = 1'b0;
    if (fifo_pop) begin
      if (fifo_count > CntW'(1)) begin
        nxt_valid   = 1'b1;
        nxt_is_load = next_is_load;
      end else if (fifo_push) begin
        nxt_valid   = 1'b1;
        nxt_is_load = in_is_load;
      end
    end else if (!fifo_empty) begin
      nxt_valid   = 1'b1;
      nxt_is_load = head_meta.is_load;
    end else if (fifo_push) begin
      nxt_valid   = 1'b1;
      nxt_is_load = in_is_load;
    end

    if (!nxt_valid) begin
      state_d = StIdle;
    end else if (nxt_is_load) begin
      state_d = StWaitMem;
    end else begin
      state_d = StIssue;
    end
  end

  // State and registered write port
  logic [4:0]        write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic              reg_write_q;
  logic [15:0]       retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      reg_write_q  <= 1'b0;
      write_reg_q  <= REG_ZERO;
      write_data_q <= '0;
      retired_q    <= '0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= issue && iss_wr;
      if (issue && iss_wr) begin
        write_reg_q  <= iss_dst;
        write_data_q <= iss_data;
        retired_q    <= retired_q + 16'd1;
      end
    end
  end

  assign write_reg   = write_reg_q;
  assign write_data  = write_data_q;
  assign reg_write   = reg_write_q;
  assign retired_cnt = retired_q;

endmodule
